rsa_cypher_host_if: RTL

Host-side controller for the RSA modular-exponentiation core; it drives the core's ds/ready start/done handshake from the initiator end.
- Deserialises message, exponent and modulus from a narrow word stream into KEYSIZE-bit operand registers.
- Launches the core with a single-cycle ds pulse, then waits for completion.
- Captures the cypher result and streams it back out as words.
- Sits between a bus/DMA word interface and the exponentiation core.

---
 rtl/rsa_host_pkg.sv | 12 +
 rtl/rsa_word_shifter.sv | 26 ++
 rtl/rsa_cypher_host_if.sv | 86 ++++++++
 3 files changed

// File: rtl/rsa_host_pkg.sv
// rsa_host_pkg: shared state type and sizing helpers for the RSA host interface
package rsa_host_pkg;
  typedef enum logic [2:0] {LOAD, ARM, START, WAIT_LOW, RUN, DRAIN} state_t;
  localparam int KEYSIZE_DEF = 2048;
  localparam int WORDW_DEF = 32;
  function automatic int nw(input int keysize, input int wordw);
    return keysize / wordw;
  endfunction
  function automatic int widx_w(input int keysize, input int wordw);
    return $clog2(3 * nw(keysize, wordw));
  endfunction
endpackage

// File: rtl/rsa_word_shifter.sv
// rsa_word_shifter: KEYSIZE-bit register with word-slot write, parallel load and right shift by one word
module rsa_word_shifter
  import rsa_host_pkg::*;
#(
  parameter int KEYSIZE = KEYSIZE_DEF,
  parameter int WORDW = WORDW_DEF,
  localparam int SW = nw(KEYSIZE, WORDW) > 1 ? $clog2(nw(KEYSIZE, WORDW)) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic [KEYSIZE-1:0] din,
  input  logic               wr,
  input  logic [SW-1:0]      slot,
  input  logic [WORDW-1:0]   wdata,
  input  logic               shift,
  output logic [WORDW-1:0]   lo
);
  logic [KEYSIZE-1:0] q;
  assign lo = q[WORDW-1:0];
  always_ff @(posedge clk or negedge reset)
    if (!reset) q <= '0;
    else if (load) q <= din;
    else if (wr) q[int'(slot)*WORDW +: WORDW] <= wdata;
    else if (shift) q <= q >> WORDW;
endmodule

// File: rtl/rsa_cypher_host_if.sv
// rsa_cypher_host_if: word-stream host controller that loads, launches and drains the RSA exponentiation core
module rsa_cypher_host_if
  import rsa_host_pkg::*;
#(
  parameter int KEYSIZE = KEYSIZE_DEF,
  parameter int WORDW = WORDW_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [WORDW-1:0]   in_word,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [WORDW-1:0]   out_word,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               busy,
  output logic [KEYSIZE-1:0] core_indata,
  output logic [KEYSIZE-1:0] core_inexp,
  output logic [KEYSIZE-1:0] core_inmod,
  output logic               core_ds,
  input  logic               core_ready,
  input  logic [KEYSIZE-1:0] core_cypher
);
  localparam int NW = nw(KEYSIZE, WORDW);
  localparam int CW = widx_w(KEYSIZE, WORDW);
  localparam logic [CW-1:0] W_NW = CW'(NW);
  localparam logic [CW-1:0] W_2NW = CW'(2 * NW);
  localparam logic [CW-1:0] W_IN_LAST = CW'(3 * NW - 1);
  localparam logic [CW-1:0] W_OUT_LAST = CW'(NW - 1);
  state_t state, state_n;
  logic [CW-1:0] widx, slot;
  logic in_fire, out_fire, cap;
  assign in_fire = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;
  assign cap = state == RUN && core_ready;
  assign busy = state != LOAD;
  assign slot = widx < W_NW ? widx : widx < W_2NW ? widx - W_NW : widx - W_2NW;
  always_comb begin
    state_n = state;
    case (state)
      LOAD:     state_n = in_fire && widx == W_IN_LAST ? ARM : LOAD;
      ARM:      state_n = core_ready ? START : ARM;
      START:    state_n = WAIT_LOW;
      WAIT_LOW: state_n = core_ready ? WAIT_LOW : RUN;
      RUN:      state_n = core_ready ? DRAIN : RUN;
      DRAIN:    state_n = out_fire && widx == W_OUT_LAST ? LOAD : DRAIN;
      default:  state_n = LOAD;
    endcase
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= LOAD;
      widx <= '0;
      in_ready <= 1'b0;
      out_valid <= 1'b0;
      core_ds <= 1'b0;
    end else begin
      state <= state_n;
      in_ready <= state_n == LOAD;
      out_valid <= state_n == DRAIN;
      core_ds <= state_n == START;
      if (in_fire || out_fire)
        widx <= (in_fire && widx == W_IN_LAST) || (out_fire && widx == W_OUT_LAST) ? '0 : widx + CW'(1);
    end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      core_indata <= '0;
      core_inexp <= '0;
      core_inmod <= '0;
    end else if (in_fire) begin
      if (widx < W_NW) core_indata[int'(slot)*WORDW +: WORDW] <= in_word;
      else if (widx < W_2NW) core_inexp[int'(slot)*WORDW +: WORDW] <= in_word;
      else core_inmod[int'(slot)*WORDW +: WORDW] <= in_word;
    end
  rsa_word_shifter #(.KEYSIZE(KEYSIZE), .WORDW(WORDW)) u_result (
    .clk(clk),
    .reset(reset),
    .load(cap),
    .din(core_cypher),
    .wr(1'b0),
    .slot('0),
    .wdata('0),
    .shift(out_fire),
    .lo(out_word)
  );
endmodule
